booth_r8_seq_mult: RTL
======================

// Module: booth_r8_seq_mult
// PURPOSE
//  Sequential radix-8 Booth multiplier. Recodes the multiplier into digits in {-4..+4}
//  and adds one partial product per cycle into a shift accumulator. 3X is precomputed once.
//  Parametrised width and per-operation signed/unsigned mode; valid/ready on input and output.
//  Sits between operand staging and the result writeback of the multiply datapath.
// PARAMETERS
//  WIDTH  16                   operand width in bits (>=4)
//  ITER   (WIDTH+3)/3          derived localparam: Booth digits = ceil((WIDTH+1)/3)
//  EW     3*ITER               derived localparam: extended multiplier width (18 @ WIDTH=16)
// PORTS
//  clk           in   1        rising-edge clock
//  rst           in   1        asynchronous, active-high reset
//  in_valid      in   1        operand request
//  in_ready      out  1        block can accept operands (high only in IDLE)
//  signed_mode   in   1        1: operands are two's complement; 0: unsigned
//  multiplicand  in   WIDTH    X
//  multiplier    in   WIDTH    Y
//  out_valid     out  1        product valid; held until accepted
//  out_ready     in   1        consumer accepts product
//  product       out  2*WIDTH  exact X*Y (two's complement if signed_mode, else unsigned)
//  busy          out  1        high in PRE and RUN
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers 0.
//  FSM: IDLE -> PRE -> RUN (ITER cycles) -> DONE -> IDLE.
//  IDLE: accept when in_valid & in_ready. Latch mode; X extended to WIDTH+3 bits; Y extended to EW bits.
//    Extension is sign extension when signed_mode=1 and zero extension when it is 0. Clear the accumulator.
//  PRE (1 cycle): register 3X = X + (X<<1) at WIDTH+3 bits. Clear the digit counter and set b[-1]=0.
//  RUN, digit i = 0..ITER-1: group g = {Y[3i+2], Y[3i+1], Y[3i], Y[3i-1]}.
//    digit = -4*g3 + 2*g2 + g1 + g0.
//    Encoding: 0000/1111 -> 0; 0001/0010 -> +X; 0011/0100 -> +2X; 0101/0110 -> +3X; 0111 -> +4X.
//    Encoding: 1000 -> -4X; 1001/1010 -> -3X; 1011/1100 -> -2X; 1101/1110 -> -X.
//    Negation: one's complement of the selected multiple plus a carry-in of 1 in the same add.
//    No separate correction row is used.
//    Accumulator: signed, AW = EW+WIDTH+3 bits. Each cycle: acc += sext(pp_i) << 3i.
//    The equivalent arithmetic-right-shift-by-3 form is also acceptable. Results must match bit for bit.
//  After the last digit: product = acc[2*WIDTH-1:0], state -> DONE, out_valid=1.
//  Latency: out_valid rises exactly ITER+2 clk edges after the accepting edge (8 @ WIDTH=16).
//  DONE: product and out_valid are held stable while out_ready=0.
//    On out_valid & out_ready: out_valid=0, state=IDLE.
//    in_ready stays 0 in that same cycle, so new operands are accepted from the next cycle.
//  Throughput: one operation per ITER+3 cycles minimum.
//  Operand inputs and signed_mode are sampled only on the accept edge. Later changes are ignored.
//  in_valid outside IDLE is ignored. There is no queuing and no error.
//  Corner cases are exact and must not overflow:
//    signed -2^(W-1) * -2^(W-1) = 2^(2W-2).
//    unsigned (2^W-1)^2.
//    any operand 0 -> product 0.
//  rst asserted mid-operation: immediate abort, return to reset values, no out_valid pulse.
//  product is registered; it changes only on entry to DONE and on reset.
// TESTING (WIDTH=16)
//  1. unsigned 0x1234*0x5678 -> product 0x06260060; out_valid exactly 8 cycles after accept.
//  2. unsigned 0xFFFF*0xFFFF -> 0xFFFE0001.
//     signed 0xFFFF*0x0001 -> 0xFFFFFFFF.
//  3. signed 0x8000*0x8000 -> 0x40000000.
//     signed 0x8000*0x7FFF -> 0xC0008000.
//  4. Backpressure: hold out_ready=0 for 20 cycles -> product stable, in_ready=0.
//     Then accept -> in_ready=1 on the next cycle.
//  5. Reset pulse in RUN cycle 3 -> outputs return to reset values, no out_valid pulse.
//     A following 7*9 (unsigned) -> 0x0000003F.
//  6. Random: 10k ops, mixed modes, back-to-back in_valid, random out_ready.
//     Every product must equal the reference model. No accept may occur outside IDLE.

Source files
------------

// File: rtl/booth_r8_seq_mult_if.sv
// Purpose : operand/result handshake bundle for booth_r8_seq_mult.
// Signals : in_valid/in_ready, signed_mode, multiplicand, multiplier (operand side);
//           out_valid/out_ready, product (result side); busy (status).
// Modports: master drives operands and out_ready, slave is the multiplier itself.
interface booth_r8_seq_mult_if #(
   parameter int unsigned WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic                 signed_mode;
   logic [WIDTH-1:0]     multiplicand;
   logic [WIDTH-1:0]     multiplier;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   product;
   logic                 busy;

   modport master (
      output in_valid, signed_mode, multiplicand, multiplier, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, signed_mode, multiplicand, multiplier, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/booth_r8_seq_mult.sv
// Purpose : sequential radix-8 Booth multiplier, one partial product per cycle,
//           3X precomputed once per operation, signed or unsigned per operation.
// Ports   : clk      - rising-edge clock
//           rst      - asynchronous active-high reset
//           mul_if   - slave side of booth_r8_seq_mult_if (operand and result handshakes)
module booth_r8_seq_mult #(
   parameter int unsigned WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst,
   booth_r8_seq_mult_if.slave  mul_if
);
   localparam int unsigned ITER = (WIDTH + 3) / 3;
   localparam int unsigned EW   = 3 * ITER;
   localparam int unsigned XW   = WIDTH + 3;
   localparam int unsigned PW   = 2 * WIDTH;
   localparam int unsigned CW   = $clog2(ITER + 1);
   localparam int unsigned SW   = $clog2(PW);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_RUN, S_DONE} state_e;

   state_e          state_q;
   logic [XW-1:0]   x_q;
   logic [XW-1:0]   x3_q;
   logic [EW-1:0]   y_q;
   logic            bprev_q;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   acc_q;
   logic [PW-1:0]   product_q;
   logic            in_ready_q;
   logic            out_valid_q;
   logic            busy_q;

   logic [3:0]      grp;
   logic [XW-1:0]   mult;
   logic            neg;
   logic [SW-1:0]   shamt;
   logic [PW-1:0]   pp_ext;
   logic [PW-1:0]   carry_in;
   logic [PW-1:0]   acc_d;

   // Current Booth group: three fresh multiplier bits plus the previous top bit
   assign grp   = {y_q[2:0], bprev_q};
   assign shamt = SW'(cnt_q) * SW'(3);

   // Digit decode: select |digit|*X and whether it is subtracted
   always_comb begin
      mult = '0;
      neg  = 1'b0;
      case (grp)
         4'b0001, 4'b0010: mult = x_q;
         4'b0011, 4'b0100: mult = {x_q[XW-2:0], 1'b0};
         4'b0101, 4'b0110: mult = x3_q;
         4'b0111:          mult = {x_q[XW-3:0], 2'b00};
         4'b1000: begin    mult = {x_q[XW-3:0], 2'b00}; neg = 1'b1; end
         4'b1001, 4'b1010: begin mult = x3_q;                 neg = 1'b1; end
         4'b1011, 4'b1100: begin mult = {x_q[XW-2:0], 1'b0};  neg = 1'b1; end
         4'b1101, 4'b1110: begin mult = x_q;                  neg = 1'b1; end
         default:          mult = '0;
      endcase
   end

   // Subtraction is one's complement plus a carry-in at the digit's weight.
   // Bits above 2*WIDTH never reach the product, so the sum is kept modulo 2^(2*WIDTH).
   assign pp_ext   = {{(PW-XW){mult[XW-1]}}, mult} ^ {PW{neg}};
   assign carry_in = PW'(neg) << shamt;
   assign acc_d    = acc_q + (pp_ext << shamt) + carry_in;

   // Control and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         x3_q        <= '0;
         y_q         <= '0;
         bprev_q     <= 1'b0;
         cnt_q       <= '0;
         acc_q       <= '0;
         product_q   <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (mul_if.in_valid && in_ready_q) begin
                  x_q        <= {{3{mul_if.signed_mode & mul_if.multiplicand[WIDTH-1]}},
                                 mul_if.multiplicand};
                  y_q        <= {{(EW-WIDTH){mul_if.signed_mode & mul_if.multiplier[WIDTH-1]}},
                                 mul_if.multiplier};
                  acc_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_PRE;
               end
            end
            S_PRE: begin
               x3_q    <= x_q + {x_q[XW-2:0], 1'b0};
               cnt_q   <= '0;
               bprev_q <= 1'b0;
               state_q <= S_RUN;
            end
            S_RUN: begin
               // One extra cycle after the last digit publishes the sum
               if (cnt_q == CW'(ITER)) begin
                  product_q   <= acc_q;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_DONE;
               end else begin
                  acc_q   <= acc_d;
                  y_q     <= {3'b000, y_q[EW-1:3]};
                  bprev_q <= y_q[2];
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            S_DONE: begin
               if (mul_if.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mul_if.in_ready  = in_ready_q;
   assign mul_if.out_valid = out_valid_q;
   assign mul_if.product   = product_q;
   assign mul_if.busy      = busy_q;
endmodule
